// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the Memory-stage load/store port. It accepts one request at a
//   time over a valid/ready handshake, performs a RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW
//   access on a byte-addressed little-endian RAM, and returns the response after
//   LATENCY cycles so that multi-cycle memory stalls can be exercised.
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   req_valid/req_ready    request handshake
//   req_write              1 = store, 0 = load
//   req_funct3             instruction funct3 (access width / extension)
//   req_addr               byte address; only the low ADDR_WIDTH bits are used
//   req_wdata              store data; the low byte/half is used for SB/SH
//   resp_valid/resp_ready  response handshake
//   resp_rdata             extended load data; 0 for stores and errors
//   resp_err               misaligned address or illegal funct3

// One byte lane of the RAM: write on the clock, combinational read.
module data_mem_lane #(
    parameter int AW    = 15,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [VEC_W-1:0] wdata,
    output logic [VEC_W-1:0] rdata
);
    logic [VEC_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module data_mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int WORD_AW   = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT                            state, stateNext;
    logic [3:0]                       cnt, cntNext;
    logic [31:0]                      respRdata;
    logic                             respErr;

    logic                             accept;
    logic [1:0]                       byteOff;
    logic [WORD_AW-1:0]               wordIdx;
    logic                             legal, misaligned, accessErr;
    logic [NUM_LANES-1:0]             laneWe;
    logic [NUM_LANES-1:0][VEC_W-1:0]  laneWdata;
    logic [NUM_LANES-1:0][VEC_W-1:0]  laneRdata;
    logic [31:0]                      readWord, shifted, loadData;
    logic [7:0]                       selByte;
    logic [15:0]                      selHalf;

    assign byteOff = req_addr[1:0];
    assign wordIdx = req_addr[ADDR_WIDTH-1:2];
    assign accept  = (state == IDLE) && req_valid;

    // Request decode: funct3[1:0] is the access width (00 byte, 01 half, 10 word);
    // the unsigned codes 100/101 exist only for loads.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_write;
            default:                legal = 1'b0;
        endcase
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        accessErr  = !legal || misaligned;
    end

    // Store lane enables and lane data; the data is replicated so each enabled
    // lane sees its own byte regardless of offset.
    always_comb begin
        laneWe    = '0;
        laneWdata = req_wdata;
        case (req_funct3[1:0])
            2'b00:   laneWdata = {NUM_LANES{req_wdata[7:0]}};
            2'b01:   laneWdata = {2{req_wdata[15:0]}};
            default: laneWdata = req_wdata;
        endcase
        if (accept && req_write && !accessErr) begin
            case (req_funct3[1:0])
                2'b00:   laneWe = 4'b0001 << byteOff;
                2'b01:   laneWe = byteOff[1] ? 4'b1100 : 4'b0011;
                default: laneWe = 4'b1111;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : genLane
        data_mem_lane #(.AW(WORD_AW), .VEC_W(VEC_W)) uLane (
            .clk   (clk),
            .we    (laneWe[g]),
            .addr  (wordIdx),
            .wdata (laneWdata[g]),
            .rdata (laneRdata[g])
        );
    end

    // Load path: pick the addressed byte/half and extend it.
    assign readWord = laneRdata;
    assign shifted  = readWord >> {byteOff, 3'b000};
    assign selByte  = shifted[7:0];
    assign selHalf  = byteOff[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        loadData = '0;
        case (req_funct3)
            3'b000:  loadData = {{24{selByte[7]}}, selByte};
            3'b001:  loadData = {{16{selHalf[15]}}, selHalf};
            3'b010:  loadData = readWord;
            3'b100:  loadData = {24'h0, selByte};
            3'b101:  loadData = {16'h0, selHalf};
            default: loadData = '0;
        endcase
        if (req_write || accessErr) loadData = '0;
    end

    // WAIT spans LATENCY-1 edges; the counter runs 0..LATENCY-2 while there.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cntNext   = '0;
                    stateNext = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'(LATENCY - 2)) stateNext = RESP;
                else                        cntNext   = cnt + 4'd1;
            end
            RESP: begin
                if (resp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            respRdata <= '0;
            respErr   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            // Response is captured at acceptance and held untouched until the next one.
            if (accept) begin
                respRdata <= loadData;
                respErr   <= accessErr;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = respRdata;
    assign resp_err   = respErr;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Three instances with LATENCY 2, 1 and 15
//   are driven independently (index 0, 1, 2); each scenario task drives stimulus and
//   compares against hand-computed values.
module tb_data_mem_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int LAT2 = 15;

    logic        clk;
    logic        rstN      [3];
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWrite  [3];
    logic [2:0]  reqFunct3 [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic        respValid [3];
    logic        respReady [3];
    logic [31:0] respRdata [3];
    logic        respErr   [3];

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rst(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(reqWrite[0]), .req_funct3(reqFunct3[0]), .req_addr(reqAddr[0]),
        .req_wdata(reqWdata[0]), .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0]));
    data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rst(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(reqWrite[1]), .req_funct3(reqFunct3[1]), .req_addr(reqAddr[1]),
        .req_wdata(reqWdata[1]), .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1]));
    data_mem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT2)) dut2 (
        .clk(clk), .rst(rstN[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_write(reqWrite[2]), .req_funct3(reqFunct3[2]), .req_addr(reqAddr[2]),
        .req_wdata(reqWdata[2]), .resp_valid(respValid[2]), .resp_ready(respReady[2]),
        .resp_rdata(respRdata[2]), .resp_err(respErr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int sel);
        return (sel == 0) ? LAT0 : (sel == 1) ? LAT1 : LAT2;
    endfunction

    // One full transaction; returns what was observed. Called #1 after an edge
    // with the DUT idle. lat = edges after acceptance until resp_valid is seen,
    // which must be LATENCY-1 (the initiator sees it at edge t+LATENCY).
    task automatic doAccess(input int sel, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic rdyIn, output logic rdyOut);
        int n;
        reqWrite[sel] = wr; reqFunct3[sel] = f3; reqAddr[sel] = addr;
        reqWdata[sel] = wdata; reqValid[sel] = 1'b1;
        rdyIn = reqReady[sel];
        @(posedge clk); #1;
        reqValid[sel] = 1'b0;
        n = 0;
        while (!respValid[sel] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        rd  = respRdata[sel];
        er  = respErr[sel];
        respReady[sel] = 1'b1;
        @(posedge clk); #1;
        respReady[sel] = 1'b0;
        rdyOut = reqReady[sel];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            if (respValid[s] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b want 0", s, respValid[s]); end
            checks++;
            if (reqReady[s] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 1", s, reqReady[s]); end
            checks++;
            if (respRdata[s] !== 32'h0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", s, respRdata[s]); end
            checks++;
            if (respErr[s] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", s, respErr[s]); end
            checks++;
        end
    endtask

    task automatic test_store_load(input int sel);
        logic [31:0] rd; logic er, ri, ro; int lat;
        doAccess(sel, 1'b1, 3'b010, 32'h100, 32'h8000_00F1, rd, er, lat, ri, ro);
        if (lat != latOf(sel) - 1) begin errors++; $display("FAIL sw_latency dut%0d: got %0d want %0d", sel, lat, latOf(sel) - 1); end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp dut%0d: got %h/%b want 0/0", sel, rd, er); end
        checks++;
        if (ri !== 1'b1 || ro !== 1'b1) begin errors++; $display("FAIL sw_ready dut%0d: got %b/%b want 1/1", sel, ri, ro); end
        checks++;
        doAccess(sel, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (lat != latOf(sel) - 1) begin errors++; $display("FAIL lw_latency dut%0d: got %0d want %0d", sel, lat, latOf(sel) - 1); end
        checks++;
        if (rd !== 32'h8000_00F1 || er !== 1'b0) begin errors++; $display("FAIL lw_data dut%0d: got %h/%b want 800000f1/0", sel, rd, er); end
        checks++;
    endtask

    task automatic test_extend(input int sel);
        logic [31:0] rd; logic er, ri, ro; int lat;
        logic [2:0]  f3v [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adv [4] = '{32'h100, 32'h100, 32'h102, 32'h102};
        logic [31:0] exv [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8000, 32'h0000_8000};
        for (int i = 0; i < 4; i++) begin
            doAccess(sel, 1'b0, f3v[i], adv[i], 32'h0, rd, er, lat, ri, ro);
            if (rd !== exv[i] || er !== 1'b0) begin errors++; $display("FAIL extend%0d dut%0d: got %h/%b want %h/0", i, sel, rd, er, exv[i]); end
            checks++;
        end
    endtask

    task automatic test_byte_store(input int sel);
        logic [31:0] rd; logic er, ri, ro; int lat;
        doAccess(sel, 1'b1, 3'b000, 32'h101, 32'h1234_56AB, rd, er, lat, ri, ro);
        doAccess(sel, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h8000_ABF1) begin errors++; $display("FAIL sb_merge dut%0d: got %h want 8000abf1", sel, rd); end
        checks++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, ri, ro; int lat;
        doAccess(0, 1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL lw_misaligned: got %h/%b want 0/1", rd, er); end
        checks++;
        if (ro !== 1'b1) begin errors++; $display("FAIL err_handshake: got ready %b want 1", ro); end
        checks++;
        doAccess(0, 1'b1, 3'b001, 32'h103, 32'h0000_FFFF, rd, er, lat, ri, ro);
        if (er !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err %b want 1", er); end
        checks++;
        doAccess(0, 1'b0, 3'b001, 32'h101, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL lh_misaligned: got %h/%b want 0/1", rd, er); end
        checks++;
        doAccess(0, 1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL funct3_011: got %h/%b want 0/1", rd, er); end
        checks++;
        // 100 is a load-only code; as a store it must be rejected without writing.
        doAccess(0, 1'b1, 3'b100, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (er !== 1'b1) begin errors++; $display("FAIL store_funct3_100: got err %b want 1", er); end
        checks++;
        doAccess(0, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h8000_ABF1) begin errors++; $display("FAIL ram_after_errors: got %h want 8000abf1", rd); end
        checks++;
        // Bit 17 and above are ignored: 0x20200 aliases 0x200.
        doAccess(0, 1'b1, 3'b010, 32'h0002_0200, 32'hCAFE_BABE, rd, er, lat, ri, ro);
        doAccess(0, 1'b0, 3'b010, 32'h0000_0200, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL addr_wrap: got %h want cafebabe", rd); end
        checks++;
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er, ri, ro; int lat, n;
        reqWrite[0] = 1'b0; reqFunct3[0] = 3'b010; reqAddr[0] = 32'h100; reqValid[0] = 1'b1;
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        n = 0;
        while (!respValid[0] && n < 40) begin @(posedge clk); #1; n++; end
        if (respValid[0] !== 1'b1) begin errors++; $display("FAIL stall_valid_timeout: got %b want 1", respValid[0]); end
        checks++;
        // Hold the response while presenting a store that must be ignored.
        for (int i = 0; i < 5; i++) begin
            reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqWdata[0] = 32'h0;
            @(posedge clk); #1;
            if (respValid[0] !== 1'b1 || respRdata[0] !== 32'h8000_ABF1 || reqReady[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b d=%h r=%b want 1/8000abf1/0", i, respValid[0], respRdata[0], reqReady[0]);
            end
            checks++;
        end
        reqValid[0] = 1'b0; reqWrite[0] = 1'b0;
        respReady[0] = 1'b1;
        @(posedge clk); #1;
        respReady[0] = 1'b0;
        if (reqReady[0] !== 1'b1 || respValid[0] !== 1'b0) begin errors++; $display("FAIL stall_release: got r=%b v=%b want 1/0", reqReady[0], respValid[0]); end
        checks++;
        doAccess(0, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h8000_ABF1) begin errors++; $display("FAIL stall_ignored_store: got %h want 8000abf1", rd); end
        checks++;
    endtask

    task automatic test_back_to_back(input int sel);
        int hits = 0;
        int t [4];
        reqWrite[sel] = 1'b0; reqFunct3[sel] = 3'b010; reqAddr[sel] = 32'h100;
        reqValid[sel] = 1'b1; respReady[sel] = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk); #1;
            if (respValid[sel] && hits < 4) begin
                t[hits] = cyc;
                if (respRdata[sel] !== 32'h8000_ABF1) begin errors++; $display("FAIL b2b_data dut%0d: got %h want 8000abf1", sel, respRdata[sel]); end
                checks++;
                hits++;
            end
        end
        reqValid[sel] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        respReady[sel] = 1'b0;
        if (hits != 4) begin errors++; $display("FAIL b2b_count dut%0d: got %0d want 4", sel, hits); end
        checks++;
        if (hits == 4) begin
            for (int i = 1; i < 4; i++) begin
                if (t[i] - t[i-1] != latOf(sel) + 1) begin
                    errors++;
                    $display("FAIL b2b_period dut%0d: got %0d want %0d", sel, t[i] - t[i-1], latOf(sel) + 1);
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, ri, ro; int lat, n;
        // Store on the LATENCY=15 instance, reset while it is still waiting.
        reqWrite[2] = 1'b1; reqFunct3[2] = 3'b010; reqAddr[2] = 32'h300;
        reqWdata[2] = 32'h5A5A_1234; reqValid[2] = 1'b1;
        @(posedge clk); #1;
        reqValid[2] = 1'b0; reqWrite[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (reqReady[2] !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got ready %b want 0", reqReady[2]); end
        checks++;
        rstN[2] = 1'b0;
        #1;
        if (respValid[2] !== 1'b0 || reqReady[2] !== 1'b1) begin errors++; $display("FAIL abort_wait_reset: got v=%b r=%b want 0/1", respValid[2], reqReady[2]); end
        checks++;
        rstN[2] = 1'b1;
        @(posedge clk); #1;
        doAccess(2, 1'b0, 3'b010, 32'h300, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'h5A5A_1234) begin errors++; $display("FAIL abort_store_kept: got %h want 5a5a1234", rd); end
        checks++;
        // Reset while a load response is being held.
        reqWrite[0] = 1'b0; reqFunct3[0] = 3'b010; reqAddr[0] = 32'h100; reqValid[0] = 1'b1;
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        n = 0;
        while (!respValid[0] && n < 40) begin @(posedge clk); #1; n++; end
        rstN[0] = 1'b0;
        #1;
        if (respValid[0] !== 1'b0 || respRdata[0] !== 32'h0 || reqReady[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_resp_reset: got v=%b d=%h r=%b want 0/0/1", respValid[0], respRdata[0], reqReady[0]);
        end
        checks++;
        rstN[0] = 1'b1;
        @(posedge clk); #1;
        doAccess(0, 1'b0, 3'b001, 32'h102, 32'h0, rd, er, lat, ri, ro);
        if (rd !== 32'hFFFF_8000 || er !== 1'b0) begin errors++; $display("FAIL after_abort_lh: got %h/%b want ffff8000/0", rd, er); end
        checks++;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            rstN[s] = 1'b0; reqValid[s] = 1'b0; reqWrite[s] = 1'b0; reqFunct3[s] = 3'b000;
            reqAddr[s] = 32'h0; reqWdata[s] = 32'h0; respReady[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        for (int s = 0; s < 3; s++) rstN[s] = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            test_store_load(s);
            test_extend(s);
            test_byte_store(s);
        end
        test_errors();
        test_stall();
        for (int s = 0; s < 3; s++) test_back_to_back(s);
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
